// File: rtl/switch_event_gen.sv
// -----------------------------------------------------------------------------
// switch_event_gen
//
// Turns a debounced, already-synchronous switch level into one-cycle event
// pulses (press, release, long-press, typematic auto-repeat) plus a held
// level, so downstream game logic never has to count hold time itself.
//
// Optional feature macro: SWITCH_EVENT_REPEAT_EN
//   defined   : REPEAT state, repeat counter and o_Repeat are built.
//   undefined : FSM stays in HELD while pressed, o_Repeat is tied to 0.
//
// Ports
//   i_Clk      in   system clock, single domain
//   i_Rst      in   synchronous reset, active-high
//   i_Switch   in   debounced switch level, 1 = pressed
//   o_Press    out  one-cycle pulse on press
//   o_Release  out  one-cycle pulse on release
//   o_Repeat   out  one-cycle auto-repeat pulse while held
//   o_Long     out  one-cycle pulse, once per press, after c_LONG_PRESS clocks
//   o_Held     out  level, high from the o_Press cycle up to the o_Release cycle
// -----------------------------------------------------------------------------
module switch_event_gen #(
    parameter int c_CNT_WIDTH     = 25,
    parameter int c_REPEAT_DELAY  = 12500000,
    parameter int c_REPEAT_PERIOD = 2500000,
    parameter int c_LONG_PRESS    = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Long,
    output logic o_Held
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
`ifdef SWITCH_EVENT_REPEAT_EN
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [c_CNT_WIDTH-1:0] c_PERIOD_C = c_CNT_WIDTH'(c_REPEAT_PERIOD);
`endif
    localparam logic [c_CNT_WIDTH-1:0] c_DELAY_C = c_CNT_WIDTH'(c_REPEAT_DELAY);
    localparam logic [c_CNT_WIDTH-1:0] c_LONG_C  = c_CNT_WIDTH'(c_LONG_PRESS);

    logic [1:0]             r_State;
    logic                   r_Prev;
    logic [c_CNT_WIDTH-1:0] r_Hold_Cnt;
    logic [c_CNT_WIDTH-1:0] w_Hold_Next;
    logic                   w_Press_Edge;
    logic                   w_Release_Edge;
    logic                   w_Hold_Sat;

    assign w_Press_Edge   =  i_Switch & ~r_Prev;
    assign w_Release_Edge = ~i_Switch &  r_Prev;
    assign w_Hold_Next    = r_Hold_Cnt + 1'b1;
    // Hold count parks at c_LONG_PRESS; this is what keeps o_Long single-shot.
    assign w_Hold_Sat     = (r_Hold_Cnt == c_LONG_C);

`ifdef SWITCH_EVENT_REPEAT_EN
    logic [c_CNT_WIDTH-1:0] r_Rpt_Cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (c_REPEAT_PERIOD < 2);
    assign o_Repeat     = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= IDLE;
            r_Prev     <= 1'b0;
            r_Hold_Cnt <= '0;
            o_Press    <= 1'b0;
            o_Release  <= 1'b0;
            o_Long     <= 1'b0;
            o_Held     <= 1'b0;
`ifdef SWITCH_EVENT_REPEAT_EN
            r_Rpt_Cnt  <= '0;
            o_Repeat   <= 1'b0;
`endif
        end else begin
            r_Prev    <= i_Switch;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Long    <= 1'b0;
`ifdef SWITCH_EVENT_REPEAT_EN
            o_Repeat  <= 1'b0;
`endif
            if (w_Press_Edge) begin
                o_Press    <= 1'b1;
                o_Held     <= 1'b1;
                r_State    <= HELD;
                r_Hold_Cnt <= '0;
            end else if (w_Release_Edge) begin
                // Release wins over any long/repeat pulse due this cycle.
                o_Release  <= 1'b1;
                o_Held     <= 1'b0;
                r_State    <= IDLE;
                r_Hold_Cnt <= '0;
`ifdef SWITCH_EVENT_REPEAT_EN
                r_Rpt_Cnt  <= '0;
`endif
            end else if (r_State != IDLE) begin
                if (!w_Hold_Sat) begin
                    r_Hold_Cnt <= w_Hold_Next;
                    o_Long     <= (w_Hold_Next == c_LONG_C);
                end
`ifdef SWITCH_EVENT_REPEAT_EN
                case (r_State)
                    HELD: begin
                        if (!w_Hold_Sat && (w_Hold_Next == c_DELAY_C)) begin
                            r_State   <= REPEAT;
                            o_Repeat  <= 1'b1;
                            r_Rpt_Cnt <= '0;
                        end
                    end
                    REPEAT: begin
                        // Reload on every repeat so the count never wraps.
                        if ((r_Rpt_Cnt + 1'b1) == c_PERIOD_C) begin
                            o_Repeat  <= 1'b1;
                            r_Rpt_Cnt <= '0;
                        end else begin
                            r_Rpt_Cnt <= r_Rpt_Cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
`else
                // Without auto-repeat the delay threshold has no effect.
                if (c_DELAY_C == '0) r_State <= HELD;
`endif
            end
        end
    end

endmodule

// File: tb/tb_switch_event_gen.sv
module tb_switch_event_gen;

    localparam int D = 10;
    localparam int P = 4;
    localparam int L = 20;

    logic i_Clk = 1'b0;
    logic i_Rst;
    logic i_Switch;
    logic o_Press, o_Release, o_Repeat, o_Long, o_Held;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_Clk = ~i_Clk;

    switch_event_gen #(
        .c_CNT_WIDTH    (8),
        .c_REPEAT_DELAY (D),
        .c_REPEAT_PERIOD(P),
        .c_LONG_PRESS   (L)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Repeat (o_Repeat),
        .o_Long   (o_Long),
        .o_Held   (o_Held)
    );

`ifdef SWITCH_EVENT_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    // Is a repeat due k cycles after T0 (k counted from the press cycle)?
    function automatic logic rpt_due(int k);
        return RPT && (k >= D) && (((k - D) % P) == 0);
    endfunction

    // Reference model: k = cycles since the press cycle of the current hold.
    // Output vector order: {press, release, repeat, long, held}.
    logic       m_prev;
    int         m_k;
    logic [4:0] exp_v;

    always @(posedge i_Clk) begin
        if (i_Rst) begin
            m_prev <= 1'b0;
            m_k    <= 0;
            exp_v  <= '0;
        end else begin
            m_prev <= i_Switch;
            if (i_Switch && !m_prev) begin
                m_k   <= 0;
                exp_v <= 5'b10001;
            end else if (i_Switch && m_prev) begin
                m_k   <= m_k + 1;
                exp_v <= {2'b00, rpt_due(m_k + 1), (m_k + 1 == L), 1'b1};
            end else if (!i_Switch && m_prev) begin
                exp_v <= 5'b01000;
            end else begin
                exp_v <= '0;
            end
        end
    end

    logic [4:0] obs  [0:63];
    logic [4:0] expm [0:63];

    // Drives one press of 'hold' sampled-high cycles and records 'len'
    // cycles of outputs starting at T0 (no checking here).
    task automatic drive_press(int hold, int len);
        i_Switch = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge i_Clk);
            obs[c]  = {o_Press, o_Release, o_Repeat, o_Long, o_Held};
            expm[c] = exp_v;
            if (c == hold - 1) i_Switch = 1'b0;
        end
        i_Switch = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] v;
        i_Rst = 1'b1;
        i_Switch = 1'b0;
        repeat (3) @(negedge i_Clk);
        v = {o_Press, o_Release, o_Repeat, o_Long, o_Held};
        n_tests++;
        if (v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp %b", v, 5'b0);
        end
        i_Rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_Clk);
            v = {o_Press, o_Release, o_Repeat, o_Long, o_Held};
            n_tests++;
            if (v !== 5'b0) begin
                n_fail++;
                $display("FAIL idle c=%0d got %b exp %b", c, v, 5'b0);
            end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] e;
        drive_press(5, 10);
        for (int c = 0; c < 10; c++) begin
            e = {(c == 0), (c == 5), 1'b0, 1'b0, (c < 5)};
            n_tests++;
            if (obs[c] !== e || expm[c] !== e) begin
                n_fail++;
                $display("FAIL short_press c=%0d got %b exp %b model %b", c, obs[c], e, expm[c]);
            end
        end
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_long_hold();
        logic [4:0] e;
        logic       r;
        int         nlong = 0;
        drive_press(30, 34);
        for (int c = 0; c < 34; c++) begin
            r = RPT && (c == 10 || c == 14 || c == 18 || c == 22 || c == 26);
            e = {(c == 0), (c == 30), r, (c == 20), (c < 30)};
            if (obs[c][1]) nlong++;
            n_tests++;
            if (obs[c] !== e || expm[c] !== e) begin
                n_fail++;
                $display("FAIL long_hold c=%0d got %b exp %b model %b", c, obs[c], e, expm[c]);
            end
        end
        n_tests++;
        if (nlong != 1) begin
            n_fail++;
            $display("FAIL long_count got %0d exp 1", nlong);
        end
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_release_on_repeat();
        logic [4:0] e;
        drive_press(14, 18);
        for (int c = 0; c < 18; c++) begin
            e = {(c == 0), (c == 14), RPT && (c == 10), 1'b0, (c < 14)};
            n_tests++;
            if (obs[c] !== e || expm[c] !== e) begin
                n_fail++;
                $display("FAIL release_on_repeat c=%0d got %b exp %b model %b", c, obs[c], e, expm[c]);
            end
        end
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] v, e;
        int         j;
        i_Switch = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge i_Clk);
            v = {o_Press, o_Release, o_Repeat, o_Long, o_Held};
            if (c < 12) begin
                e = {(c == 0), 1'b0, RPT && (c == 10), 1'b0, 1'b1};
            end else if (c < 14) begin
                e = 5'b0;
            end else begin
                j = c - 14;
                e = {(j == 0), 1'b0, rpt_due(j), 1'b0, 1'b1};
            end
            n_tests++;
            if (v !== e || exp_v !== e) begin
                n_fail++;
                $display("FAIL reset_mid_hold c=%0d got %b exp %b model %b", c, v, e, exp_v);
            end
            if (c == 11) i_Rst = 1'b1;
            if (c == 13) i_Rst = 1'b0;
        end
        i_Switch = 1'b0;
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_random();
        logic [4:0] v;
        int         run = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge i_Clk);
            v = {o_Press, o_Release, o_Repeat, o_Long, o_Held};
            n_tests++;
            if (v !== exp_v) begin
                n_fail++;
                $display("FAIL random c=%0d got %b exp %b", c, v, exp_v);
            end
            i_Rst = ($urandom_range(0, 199) == 0);
            if (run == 0) begin
                i_Switch = ~i_Switch;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 40);
            end else begin
                run--;
            end
        end
        i_Rst = 1'b0;
        i_Switch = 1'b0;
        repeat (3) @(negedge i_Clk);
    endtask

    initial begin
        i_Rst = 1'b1;
        i_Switch = 1'b0;
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_on_repeat();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
